gf3m_mulx_iter: RTL and testbench



---
 rtl/gf3_pkg.sv | 21 ++
 rtl/gf3m_mulx_step.sv | 27 ++
 rtl/gf3m_mulx_iter.sv | 74 +++++++
 tb/tb_gf3m_mulx_iter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/gf3_pkg.sv
// gf3_pkg: shared GF(3^97) constants, coefficient encoding, FSM states and F3 arithmetic
package gf3_pkg;
    localparam int M   = 97;
    localparam int W   = 2 * M;
    localparam int TAP = 12;
    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction
    function automatic logic [1:0] f3_neg(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction
    function automatic logic [1:0] f3_sub(input logic [1:0] a, input logic [1:0] b);
        return f3_add(a, f3_neg(b));
    endfunction
endpackage

// File: rtl/gf3m_mulx_step.sv
// gf3m_mulx_step: one combinational multiply-by-x (and optional divide-by-x) step modulo x^97 + x^12 + 2
module gf3m_mulx_step
    import gf3_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] c
);
    // shift coefficients up one place; the top coefficient folds back as x^97 = 2x^12 + 1
    always_comb begin
        c = {a[W-3:0], a[W-1:W-2]};
        c[2*TAP+1:2*TAP] = f3_sub(a[2*TAP-1:2*TAP-2], a[W-1:W-2]);
    end
endmodule

// gf3m_divx_step: one combinational divide-by-x step, using x^-1 = x^96 + x^11
module gf3m_divx_step
    import gf3_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] c
);
    // shift coefficients down one place; the constant coefficient feeds x^96 and x^11
    always_comb begin
        c = {a[1:0], a[W-1:2]};
        c[2*TAP-1:2*TAP-2] = f3_add(a[2*TAP+1:2*TAP], a[1:0]);
    end
endmodule

// File: rtl/gf3m_mulx_iter.sv
// gf3m_mulx_iter: iterative C = A * x^K mod (x^97 + x^12 + 2), one step per clock; GF3M_MULX_DIR_EN adds a divide direction
module gf3m_mulx_iter
    import gf3_pkg::*;
#(
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
`ifdef GF3M_MULX_DIR_EN
    input  logic          dir,
`endif
    input  logic [KW-1:0] K,
    input  logic [W-1:0]  A,
    output logic [W-1:0]  C,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic [W-1:0]  c_q, c_d, mul_c, step_c;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          load;
    assign load = (state_q == IDLE) && start;
    gf3m_mulx_step u_mul (.a(c_q), .c(mul_c));
`ifdef GF3M_MULX_DIR_EN
    logic [W-1:0] div_c;
    logic         dir_q;
    gf3m_divx_step u_div (.a(c_q), .c(div_c));
    assign step_c = dir_q ? div_c : mul_c;
    // direction is captured with the accepted start and held for the whole operation
    always_ff @(posedge clk) begin
        if (reset) dir_q <= 1'b0;
        else if (load) dir_q <= dir;
    end
`else
    assign step_c = mul_c;
`endif
    // state, operand and step counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state: IDLE waits for start, RUN steps until the count is exhausted, DONE lasts one cycle
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE)
                : (state_q == RUN)  ? ((cnt_q == '0) ? DONE : RUN)
                : IDLE;
    end
    // datapath: load on accepted start, otherwise step while RUN has steps left, else hold
    always_comb begin
        c_d   = c_q;
        cnt_d = cnt_q;
        if (load) begin
            c_d   = A;
            cnt_d = K;
        end else if (state_q == RUN && cnt_q != '0) begin
            c_d   = step_c;
            cnt_d = cnt_q - 1'b1;
        end
    end
    // outputs decode registered state only
    always_comb begin
        C    = c_q;
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end
endmodule

// File: tb/tb_gf3m_mulx_iter.sv
// tb_gf3m_mulx_iter: scoreboard bench for gf3m_mulx_iter (define GF3M_MULX_DIR_EN to cover the divide direction)
`timescale 1ns/1ps
module tb_gf3m_mulx_iter;
    localparam int W  = 194;
    localparam int KW = 8;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [KW-1:0] K = '0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  C;
    logic          busy, done;
    logic [W-1:0]  expq[$];
    int            applied = 0;
    int            miscompares = 0;

    gf3m_mulx_iter #(.KW(KW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef GF3M_MULX_DIR_EN
        .dir(dir),
`endif
        .K(K),
        .A(A),
        .C(C),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (expq.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 with C=%h, expected no pulse", C);
            end else begin
                chk("result", C, expq.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input int k, input logic d);
        @(negedge clk);
        A = a; K = KW'(k); dir = d; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = '0; K = '0; dir = 1'b0;
    endtask

    // issue one operation, queue its result, check done timing and busy
    task automatic run(input string name, input logic [W-1:0] a, input int k, input logic d, input logic [W-1:0] exp);
        int  n;
        bit  busy_ok;
        expq.push_back(exp);
        @(negedge clk);
        A = a; K = KW'(k); dir = d; start = 1'b1;
        @(posedge clk);
        n = 0;
        busy_ok = 1;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0; A = '0; K = '0; dir = 1'b0;
            if (busy !== 1'b1) busy_ok = 0;
        end while (done !== 1'b1 && n <= k + 10);
        chk({name, "_done_edge"}, W'(n), W'(k + 1));
        chk({name, "_busy"}, W'(busy_ok), W'(1));
        @(negedge clk);
        chk({name, "_done_fall"}, W'({busy, done}), W'(0));
    endtask

    logic [W-1:0] rnd;
    logic [W-1:0] x96, x95, red;

    initial begin
        x96 = '0; x96[192] = 1'b1;
        x95 = '0; x95[190] = 1'b1;
        red = '0; red[25] = 1'b1; red[0] = 1'b1;
        rnd = '0;
        for (int i = 0; i < 97; i++) rnd[2*i +: 2] = 2'($urandom_range(2));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_C", C, '0);
        chk("reset_flags", W'({busy, done}), W'(0));
        run("one_k1", W'(1), 1, 1'b0, W'(4));
        run("x96_k1", x96, 1, 1'b0, red);
        run("one_k97", W'(1), 97, 1'b0, red);
        run("x95_k2", x95, 2, 1'b0, red);
        run("two_k96", W'(2), 96, 1'b0, W'(2) << 192);
        run("rand_k0", rnd, 0, 1'b0, rnd);
        chk("hold_after_done", C, rnd);
        // start re-asserted mid-run is ignored
        expq.push_back(W'(1) << 10);
        issue(W'(1), 5, 1'b0);
        @(negedge clk);
        A = x96; K = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrun_start_idle", W'(busy), W'(0));
        // reset mid-run aborts cleanly
        issue(W'(1), 50, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_reset_C", C, '0);
        chk("midrun_reset_busy", W'(busy), W'(0));
        chk("midrun_reset_done", W'(done), W'(0));
        run("after_reset_k2", W'(1), 2, 1'b0, W'(16));
`ifdef GF3M_MULX_DIR_EN
        run("div_x", W'(4), 1, 1'b1, W'(1));
        run("div_red", red, 1, 1'b1, x96);
        run("dir0_same", x96, 1, 1'b0, red);
`endif
        repeat (5) @(negedge clk);
        chk("queue_drained", W'(expq.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
